baccarat_table: RTL

Parametrised multi-seat baccarat round engine: it deals NUM_SEATS player hands plus one dealer hand from an external card source and applies the third-card rules. It resolves each seat against the dealer and keeps saturating result tallies across rounds. It replaces the fixed one-player datapath/statemachine pair and sits between the card generator and the HEX/LED display logic.

---
 rtl/baccarat_pkg.sv | 50 +++++
 rtl/baccarat_hand.sv | 47 ++++
 rtl/baccarat_table.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and card arithmetic for the multi-seat baccarat round engine.
package baccarat_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDeal,
    StNat,
    StSeat3,
    StDealer3,
    StResolve,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ResNone = 2'd0,
    ResWin  = 2'd1,
    ResLose = 2'd2,
    ResTie  = 2'd3
  } result_e;

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] score, input logic [3:0] value);
    logic [4:0] sum;
    sum = {1'b0, score} + {1'b0, value};
    return (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  endfunction

  // p is the value of the third card taken by seat 0, meaningful only when seat0_drew.
  function automatic logic dealer_draws(input logic [3:0] dscore, input logic seat0_drew,
                                        input logic [3:0] p);
    logic draw;
    if (!seat0_drew) begin
      draw = (dscore <= 4'd5);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (p != 4'd8);
        4'd4:             draw = (p >= 4'd2) && (p <= 4'd7);
        4'd5:             draw = (p >= 4'd4) && (p <= 4'd7);
        4'd6:             draw = (p >= 4'd6) && (p <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
    return draw;
  endfunction

endpackage

// File: rtl/baccarat_hand.sv
// One baccarat hand: running mod-10 score, two-card natural flag and third-card value.
module baccarat_hand
  import baccarat_pkg::*;
(
  input  logic       fast_clock,
  input  logic       resetb,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] rank,
  output logic [3:0] score,
  output logic       natural,
  output logic       drew,
  output logic [3:0] third
);

  logic [1:0] count;
  logic [3:0] value;
  logic [3:0] next_score;

  assign value      = card_value(rank);
  assign next_score = add_mod10(score, value);

  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      score   <= 4'd0;
      natural <= 1'b0;
      drew    <= 1'b0;
      third   <= 4'd0;
      count   <= 2'd0;
    end else if (clear) begin
      score   <= 4'd0;
      natural <= 1'b0;
      drew    <= 1'b0;
      third   <= 4'd0;
      count   <= 2'd0;
    end else if (load) begin
      score <= next_score;
      if (count != 2'd3) count <= count + 2'd1;
      if (count == 2'd1) natural <= (next_score >= 4'd8);
      if (count == 2'd2) begin
        drew  <= 1'b1;
        third <= value;
      end
    end
  end

endmodule

// File: rtl/baccarat_table.sv
// Multi-seat baccarat round engine: deals seats plus dealer, applies third-card rules,
// resolves each seat against the dealer and keeps saturating outcome tallies.
module baccarat_table
  import baccarat_pkg::*;
#(
  parameter int unsigned NUM_SEATS = 1,
  parameter int unsigned TALLY_W   = 8
) (
  input  logic                   fast_clock,
  input  logic                   resetb,
  input  logic                   start,
  output logic                   card_req,
  input  logic                   card_valid,
  input  logic [3:0]             card_in,
  output logic [4*NUM_SEATS-1:0] seat_score,
  output logic [3:0]             dscore,
  output logic [2*NUM_SEATS-1:0] seat_result,
  output logic                   round_done,
  output logic                   busy,
  output logic [TALLY_W-1:0]     player_tally,
  output logic [TALLY_W-1:0]     dealer_tally,
  output logic [TALLY_W-1:0]     tie_tally
);

  localparam int unsigned NumHands = NUM_SEATS + 1;
  localparam int unsigned NumDeal  = 2 * NumHands;
  localparam int unsigned IdxW     = $clog2(NumDeal);
  localparam int unsigned SeatW    = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1;

  state_e                 state;
  logic [IdxW-1:0]        deal_idx;
  logic [IdxW-1:0]        deal_hand;
  logic [SeatW-1:0]       seat;
  logic                   transfer;
  logic                   clear;
  logic                   last_seat;
  logic                   nat;
  logic                   dealer_draw;
  logic [NUM_SEATS-1:0]   seat_stands;
  logic [3:0]             score_h   [NumHands];
  logic                   natural_h [NumHands];
  logic                   drew_h    [NumHands];
  logic [3:0]             third_h   [NumHands];
  logic [2*NUM_SEATS-1:0] result_next;
  logic [2:0]             n_win, n_lose, n_tie;

  assign transfer    = card_req && card_valid;
  assign clear       = start && ((state == StIdle) || (state == StDone));
  assign busy        = (state != StIdle) && (state != StDone);
  // Dealing runs round-robin over seats then dealer, twice.
  assign deal_hand   = (deal_idx < IdxW'(NumHands)) ? deal_idx : deal_idx - IdxW'(NumHands);
  assign last_seat   = (seat == SeatW'(NUM_SEATS - 1));
  assign nat         = natural_h[0] || natural_h[NUM_SEATS];
  assign dealer_draw = dealer_draws(score_h[NUM_SEATS], drew_h[0], third_h[0]);
  assign dscore      = score_h[NUM_SEATS];

  for (genvar h = 0; h < NumHands; h++) begin : g_hand
    logic sel;
    if (h < NUM_SEATS) begin : g_seat
      assign sel = ((state == StDeal) && (deal_hand == IdxW'(h))) ||
                   ((state == StSeat3) && (seat == SeatW'(h)));
      assign seat_score[4*h +: 4] = score_h[h];
      assign seat_stands[h]       = (score_h[h] >= 4'd6) || natural_h[h];
    end else begin : g_dealer
      assign sel = ((state == StDeal) && (deal_hand == IdxW'(h))) || (state == StDealer3);
    end

    baccarat_hand u_hand (
      .fast_clock (fast_clock),
      .resetb     (resetb),
      .clear      (clear),
      .load       (transfer && sel),
      .rank       (card_in),
      .score      (score_h[h]),
      .natural    (natural_h[h]),
      .drew       (drew_h[h]),
      .third      (third_h[h])
    );
  end

  always_comb begin
    result_next = '0;
    n_win       = 3'd0;
    n_lose      = 3'd0;
    n_tie       = 3'd0;
    for (int s = 0; s < NUM_SEATS; s++) begin
      if (score_h[s] > dscore) begin
        result_next[2*s +: 2] = ResWin;
        n_win = n_win + 3'd1;
      end else if (score_h[s] < dscore) begin
        result_next[2*s +: 2] = ResLose;
        n_lose = n_lose + 3'd1;
      end else begin
        result_next[2*s +: 2] = ResTie;
        n_tie = n_tie + 3'd1;
      end
    end
  end

  function automatic logic [TALLY_W-1:0] sat_add(input logic [TALLY_W-1:0] a,
                                                 input logic [2:0] b);
    logic [TALLY_W+2:0] sum;
    sum = {3'b000, a} + {{TALLY_W{1'b0}}, b};
    return (sum > {3'b000, {TALLY_W{1'b1}}}) ? {TALLY_W{1'b1}} : sum[TALLY_W-1:0];
  endfunction

  // In SEAT3/DEALER3 card_req low marks the decision cycle, high the wait for the card.
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      state        <= StIdle;
      card_req     <= 1'b0;
      round_done   <= 1'b0;
      deal_idx     <= '0;
      seat         <= '0;
      seat_result  <= '0;
      player_tally <= '0;
      dealer_tally <= '0;
      tie_tally    <= '0;
    end else begin
      round_done <= 1'b0;
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state       <= StDeal;
            card_req    <= 1'b1;
            deal_idx    <= '0;
            seat_result <= '0;
          end
        end
        StDeal: begin
          if (transfer) begin
            if (deal_idx == IdxW'(NumDeal - 1)) begin
              card_req <= 1'b0;
              state    <= StNat;
            end else begin
              deal_idx <= deal_idx + 1'b1;
            end
          end
        end
        StNat: begin
          seat  <= '0;
          state <= nat ? StResolve : StSeat3;
        end
        StSeat3: begin
          if (!card_req) begin
            if (seat_stands[seat]) begin
              if (last_seat) state <= StDealer3;
              else seat <= seat + 1'b1;
            end else begin
              card_req <= 1'b1;
            end
          end else if (transfer) begin
            card_req <= 1'b0;
            if (last_seat) state <= StDealer3;
            else seat <= seat + 1'b1;
          end
        end
        StDealer3: begin
          if (!card_req) begin
            if (dealer_draw) card_req <= 1'b1;
            else state <= StResolve;
          end else if (transfer) begin
            card_req <= 1'b0;
            state    <= StResolve;
          end
        end
        StResolve: begin
          seat_result  <= result_next;
          player_tally <= sat_add(player_tally, n_win);
          dealer_tally <= sat_add(dealer_tally, n_lose);
          tie_tally    <= sat_add(tie_tally, n_tie);
          round_done   <= 1'b1;
          state        <= StDone;
        end
        default: begin
          state    <= StIdle;
          card_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
